// File: rtl/fetch_ctrl_if.sv
// Handshake/bus bundle between the host/decode side and the fetch controller.
// The host drives requests and branch/halt status; the controller returns the PC and run status.
interface fetch_ctrl_if #(
    parameter int PC_W = 10
);
    logic            req;
    logic            stall;
    logic            halt;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] pc;
    logic            valid;
    logic            done;
    logic            timeout;
    logic [15:0]     instr_count;

    modport master (
        output req, stall, halt, branch_taken, branch_target,
        input  pc, valid, done, timeout, instr_count
    );

    modport slave (
        input  req, stall, halt, branch_taken, branch_target,
        output pc, valid, done, timeout, instr_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: IDLE -> LOAD -> RUN -> DONE, with branch redirect,
// stall hold, HALT detection and a RUN-cycle watchdog. Every output comes straight from a register.
module fetch_ctrl #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0,
    parameter int MAX_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.slave  bus
);
    localparam int CYC_W = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_reg;
    logic [PC_W-1:0]   pc_reg;
    logic              valid_reg;
    logic              done_reg;
    logic              timeout_reg;
    logic [15:0]       instr_count_reg;
    logic [CYC_W-1:0]  cycle_reg;

    logic [PC_W-1:0]   pc_next;
    logic [15:0]       instr_count_next;
    logic              watchdog_hit;
    logic              retire;

    always_comb begin
        pc_next          = pc_reg + PC_W'(1);
        instr_count_next = instr_count_reg;
        retire           = ~bus.stall;
        // This is the last RUN cycle the watchdog allows.
        watchdog_hit     = (cycle_reg == CYC_W'(MAX_CYCLES - 1));
        if (bus.branch_taken) begin
            pc_next = bus.branch_target;
        end
        if (instr_count_reg != 16'hFFFF) begin
            instr_count_next = instr_count_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            pc_reg          <= '0;
            valid_reg       <= 1'b0;
            done_reg        <= 1'b0;
            timeout_reg     <= 1'b0;
            instr_count_reg <= '0;
            cycle_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    valid_reg <= 1'b0;
                    done_reg  <= 1'b0;
                    if (bus.req) begin
                        state_reg <= LOAD;
                    end
                end

                LOAD: begin
                    pc_reg          <= PC_W'(START_ADDR);
                    instr_count_reg <= '0;
                    cycle_reg       <= '0;
                    timeout_reg     <= 1'b0;
                    valid_reg       <= 1'b1;
                    state_reg       <= RUN;
                end

                RUN: begin
                    cycle_reg <= cycle_reg + CYC_W'(1);
                    if (retire && bus.halt) begin
                        // HALT wins over branch and over a simultaneous watchdog expiry.
                        instr_count_reg <= instr_count_next;
                        valid_reg       <= 1'b0;
                        done_reg        <= 1'b1;
                        timeout_reg     <= 1'b0;
                        state_reg       <= DONE;
                    end else begin
                        if (retire) begin
                            pc_reg          <= pc_next;
                            instr_count_reg <= instr_count_next;
                        end
                        if (watchdog_hit) begin
                            valid_reg   <= 1'b0;
                            done_reg    <= 1'b1;
                            timeout_reg <= 1'b1;
                            state_reg   <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (!bus.req) begin
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = pc_reg;
    assign bus.valid       = valid_reg;
    assign bus.done        = done_reg;
    assign bus.timeout     = timeout_reg;
    assign bus.instr_count = instr_count_reg;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: start/halt, branch wrap, stall priority, watchdog,
// halt-versus-watchdog tie, DONE handshake and asynchronous mid-run reset.
module tb_fetch_ctrl;
    localparam int PC_W = 10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_ctrl_if #(.PC_W(PC_W)) bus ();

    fetch_ctrl #(
        .PC_W       (PC_W),
        .START_ADDR (0),
        .MAX_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc_e, input logic v_e,
                               input logic d_e, input logic t_e, input logic [31:0] cnt_e);
        check({tag, ".pc"},      32'(bus.pc), pc_e);
        check({tag, ".valid"},   32'(bus.valid), 32'(v_e));
        check({tag, ".done"},    32'(bus.done), 32'(d_e));
        check({tag, ".timeout"}, 32'(bus.timeout), 32'(t_e));
        check({tag, ".count"},   32'(bus.instr_count), cnt_e);
        $display("step %-12s pc=%0d valid=%0b done=%0b timeout=%0b count=%0d",
                 tag, bus.pc, bus.valid, bus.done, bus.timeout, bus.instr_count);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset             = 1'b0;
        bus.req           = 1'b0;
        bus.stall         = 1'b0;
        bus.halt          = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;

        #3;
        check_state("reset", 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_state("idle_noreq", 0, 0, 0, 0, 0);

        // Start and halt on the 5th valid instruction.
        bus.req = 1'b1;
        tick();
        check("load.valid", 32'(bus.valid), 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_state($sformatf("run_pc%0d", i), i, 1, 0, 0, i);
            bus.halt = (i == 4);
            tick();
        end
        check_state("halted", 4, 0, 1, 0, 5);
        bus.halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("done_hold", 32'(bus.done), 1);
        end
        check_state("done_held", 4, 0, 1, 0, 5);
        bus.req = 1'b0;
        tick();
        check("to_idle.done", 32'(bus.done), 0);

        // Branch to all-ones then wrap; req dropped during LOAD must not abort.
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        tick();
        check_state("br_start", 0, 1, 0, 0, 0);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 10'd1023;
        tick();
        check_state("br_target", 1023, 1, 0, 0, 1);
        bus.branch_taken = 1'b0;
        tick();
        check_state("br_wrap", 0, 1, 0, 0, 2);
        bus.halt = 1'b1;
        tick();
        check_state("br_halt", 0, 0, 1, 0, 3);
        bus.halt = 1'b0;
        tick();
        check("br_idle.done", 32'(bus.done), 0);

        // Stall holds pc/count and masks halt+branch; on release halt wins.
        bus.req = 1'b1;
        tick();
        tick();
        check_state("st_start", 0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) tick();
        check_state("st_pc7", 7, 1, 0, 0, 7);
        bus.stall         = 1'b1;
        bus.halt          = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 10'd100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state($sformatf("st_hold%0d", i), 7, 1, 0, 0, 7);
        end
        bus.stall = 1'b0;
        tick();
        check_state("st_release", 7, 0, 1, 0, 8);
        bus.halt         = 1'b0;
        bus.branch_taken = 1'b0;
        bus.req          = 1'b0;
        tick();
        check("st_idle.done", 32'(bus.done), 0);

        // Watchdog with stall toggling: 8 of 16 RUN cycles retire.
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        tick();
        for (int k = 1; k <= 16; k++) begin
            bus.stall = (k % 2 == 0);
            tick();
            if (k < 16) check($sformatf("wd_run%0d.done", k), 32'(bus.done), 0);
        end
        check_state("wd_fire", 8, 0, 1, 1, 8);
        bus.stall = 1'b0;
        tick();
        check("wd_idle.done", 32'(bus.done), 0);

        // Halt retiring on the watchdog cycle reports a clean halt.
        bus.req = 1'b1;
        tick();
        tick();
        bus.req = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            bus.halt = (k == 16);
            tick();
        end
        check_state("tie", 15, 0, 1, 0, 16);
        bus.halt = 1'b0;
        tick();
        check("tie_idle.done", 32'(bus.done), 0);

        // Reset between edges mid-run clears everything immediately.
        bus.req = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check_state("rst_pre", 2, 1, 0, 0, 2);
        #2;
        reset = 1'b0;
        #1;
        check_state("rst_async", 0, 0, 0, 0, 0);
        tick();
        check_state("rst_held", 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        check("rst_load.valid", 32'(bus.valid), 0);
        tick();
        check_state("rst_rerun", 0, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout_guard observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
